// File: rtl/video_cmd_pkg.sv
// Shared definitions for the video processor custom-instruction port:
// decoder field layout of dataA/dataB, opcodes, FSM encoding and defaults.
package video_cmd_pkg;

  localparam int CMD_W = 64;
  localparam int DEFAULT_HOLD_CYCLES = 4;

  // dataA layout as seen by the processor's decoder
  localparam int OPC_LSB  = 28;
  localparam int OPC_W    = 4;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 16;

  localparam logic [OPC_W-1:0] OPC_BACKGROUND = 4'h1;
  localparam logic [OPC_W-1:0] OPC_SPRITE_REG = 4'h2;
  localparam logic [OPC_W-1:0] OPC_SPRITE_MEM = 4'h3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HOLD  = 2'd2
  } issue_state_e;

  function automatic logic [31:0] make_cmd_a(input logic [OPC_W-1:0] opc,
                                             input logic [ADDR_W-1:0] addr);
    logic [31:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W]   = opc;
    w[ADDR_LSB +: ADDR_W] = addr;
    return w;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with registered full/empty and entry count; 0-cycle read of head.
// Pushes while full and pops while empty are ignored; the owner flags drops.
module cmd_fifo
  import video_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = CMD_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop_vld,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_vld && !full;
  assign pop_ok  = pop_vld && !empty;
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tells full from empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/video_cmd_issuer.sv
// Queues {dataA,dataB} pairs and replays each as a start pulse plus HOLD_CYCLES of held operands.
// Push-to-start latency 2 cycles; issue stalls while the synchronized screen flag is set; drops on full set overflow.
module video_cmd_issuer
  import video_cmd_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [31:0]            wr_dataA,
  input  logic [31:0]            wr_dataB,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clear_overflow,
  input  logic                   in_printtingScreen,
  output logic [31:0]            dataA,
  output logic [31:0]            dataB,
  output logic                   start,
  output logic                   clk_en,
  output logic                   busy
);

  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  issue_state_e           state;
  issue_state_e           state_nxt;
  logic [HCW-1:0]         hold_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   screen;
  logic                   pop;
  logic [CMD_W-1:0]       head;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (wr_en),
    .push_dat ({wr_dataA, wr_dataB}),
    .pop_vld  (pop),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty),
    .count    (level)
  );

  assign screen = sync_q[SYNC_STAGES-1];
  assign pop    = (state == ST_IDLE) && !empty && !screen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (pop) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_HOLD;
      ST_HOLD:  if (hold_cnt == '0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    start  = (state == ST_ISSUE);
    clk_en = (state == ST_ISSUE) || (state == ST_HOLD);
    busy   = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      hold_cnt <= '0;
      dataA    <= '0;
      dataB    <= '0;
      overflow <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_printtingScreen};
      if (pop) {dataA, dataB} <= head;
      if (state == ST_ISSUE)
        hold_cnt <= HCW'(HOLD_CYCLES - 1);
      else if (state == ST_HOLD && hold_cnt != '0)
        hold_cnt <= hold_cnt - 1'b1;
      // A dropped push wins over a simultaneous clear.
      if (wr_en && full)       overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule
